flostamp: RTL and testbench

FLOSTAMP -- requirements
Module: flostamp

---
 rtl/flostamp.sv | 119 +++++++++++
 tb/tb_flostamp.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/flostamp.sv
`default_nettype none
// ============================================================================
// Module   : flostamp
// Purpose  : Encodes timed event strobes into {delay, data} words and queues
//            them in a small FIFO for a downstream delay-decoding buffer.
// Options  : FLOSTAMP_FILLER_EN - emit {127, last data} filler words so gaps
//            longer than 127 idle cycles keep their absolute timing.
// Revision : 1.0 - initial release
// ============================================================================
module flostamp #(
  parameter int fifo_size = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_i,
  input  logic        stb_i,
  input  logic        full_i,
  output logic [15:0] data_o,
  output logic [6:0]  delay_o,
  output logic        valid_o,
  output logic        empty_o,
  output logic        err_o
);

  localparam int              c_AW       = $clog2(fifo_size);
  localparam logic [c_AW:0]   c_DEPTH    = (c_AW+1)'(fifo_size);
  localparam logic [c_AW-1:0] c_PTR_ONE  = (c_AW)'(1);
  localparam logic [6:0]      c_GAP_MAX  = 7'd127;
  localparam logic [0:0]      c_IDLE     = 1'b0;
  localparam logic [0:0]      c_RUN      = 1'b1;

  logic [0:0]      r_state;
  logic [6:0]      r_gap;
  logic [15:0]     r_last_data;
  logic [22:0]     r_mem [fifo_size];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;
  logic            r_valid;
  logic            r_err;
  logic            r_empty;
  logic [15:0]     r_data;
  logic [6:0]      r_delay;

  logic [6:0]      w_gap_inc;
  logic            w_filler;
  logic            w_wr;
  logic [22:0]     w_wr_word;
  logic            w_pop;
  logic            w_full;
  logic            w_accept;
  logic [c_AW:0]   w_count_next;

  always_comb begin
    w_gap_inc = (r_gap == c_GAP_MAX) ? r_gap : r_gap + 7'd1;
`ifdef FLOSTAMP_FILLER_EN
    // The filler fires on the idle cycle that brings the gap to 127, so the
    // filler itself accounts for that cycle and no idle time is lost.
    w_filler  = (r_state == c_RUN) && !stb_i && (w_gap_inc == c_GAP_MAX);
`else
    w_filler  = 1'b0;
`endif
    w_wr         = stb_i || w_filler;
    w_wr_word    = stb_i ? {r_gap, data_i} : {c_GAP_MAX, r_last_data};
    w_pop        = (r_count != '0) && !full_i;
    w_full       = (r_count == c_DEPTH);
    w_accept     = w_wr && (!w_full || w_pop);
    w_count_next = r_count + (c_AW+1)'(w_accept) - (c_AW+1)'(w_pop);
  end

  // Storage carries no reset; validity is defined entirely by the pointers.
  always_ff @(posedge clk) begin
    if (rst_n && w_accept) begin
      r_mem[r_wr_ptr] <= w_wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= c_IDLE;
      r_gap       <= 7'd0;
      r_last_data <= 16'd0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_empty     <= 1'b1;
      r_data      <= 16'd0;
      r_delay     <= 7'd0;
    end else begin
      r_gap <= w_wr ? 7'd0 : w_gap_inc;
      if (stb_i) begin
        r_state     <= c_RUN;
        r_last_data <= data_i;
      end
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        r_data   <= r_mem[r_rd_ptr][15:0];
        r_delay  <= r_mem[r_rd_ptr][22:16];
      end
      r_valid <= w_pop;
      r_err   <= w_wr && !w_accept;
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
    end
  end

  assign data_o  = r_data;
  assign delay_o = r_delay;
  assign valid_o = r_valid;
  assign empty_o = r_empty;
  assign err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_flostamp.sv
`default_nettype none
// ============================================================================
// Module   : tb_flostamp
// Purpose  : Directed, table-driven bench for flostamp (fifo_size = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_flostamp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_i;
  logic        stb_i;
  logic        full_i;
  logic [15:0] data_o;
  logic [6:0]  delay_o;
  logic        valid_o;
  logic        empty_o;
  logic        err_o;

  always #5 clk = ~clk;

  flostamp #(.fifo_size(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .stb_i   (stb_i),
    .full_i  (full_i),
    .data_o  (data_o),
    .delay_o (delay_o),
    .valid_o (valid_o),
    .empty_o (empty_o),
    .err_o   (err_o)
  );

  typedef struct {
    logic        rst_n;
    logic        stb;
    logic [15:0] din;
    logic        full;
    logic        ev;
    logic [15:0] ed;
    logic [6:0]  edl;
    logic        ee;
    logic        eerr;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic r, input logic s, input logic [15:0] d,
                              input logic f, input logic ev, input logic [15:0] ed,
                              input logic [6:0] edl, input logic ee, input logic eerr);
    vec_t v;
    v.rst_n = r; v.stb = s; v.din = d; v.full = f;
    v.ev = ev; v.ed = ed; v.edl = edl; v.ee = ee; v.eerr = eerr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic r, input logic s, input logic [15:0] d, input logic f);
    @(negedge clk);
    rst_n = r; stb_i = s; data_i = d; full_i = f;
    @(posedge clk);
    #1;
  endtask

  logic [22:0] got[$];
  logic [22:0] exp_words[$];
  bit          err_seen;

  initial begin
    rst_n = 1'b0; stb_i = 1'b0; data_i = 16'd0; full_i = 1'b0;

    // reset with a strobe present, then 3 idle cycles and event 0x1234
    vecs.push_back(mk(0, 1, 16'hFFFF, 0, 0, 16'h0000, 0, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0));
    vecs.push_back(mk(1, 1, 16'h1234, 0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h1234, 3, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h1234, 3, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h1234, 3, 1, 0));
    // back-to-back strobes A, B, C
    vecs.push_back(mk(1, 1, 16'h000A, 0, 0, 16'h1234, 3, 0, 0));
    vecs.push_back(mk(1, 1, 16'h000B, 0, 1, 16'h000A, 3, 0, 0));
    vecs.push_back(mk(1, 1, 16'h000C, 0, 1, 16'h000B, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h000C, 0, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h000C, 0, 1, 0));
    // five strobes into a stalled 4-deep FIFO
    vecs.push_back(mk(1, 1, 16'h0011, 1, 0, 16'h000C, 0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0022, 1, 0, 16'h000C, 0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0033, 1, 0, 16'h000C, 0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0044, 1, 0, 16'h000C, 0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0055, 1, 0, 16'h000C, 0, 0, 1));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 16'h000C, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0011, 2, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0022, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0033, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0044, 0, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0044, 0, 1, 0));
    // fill to 4, then write and pop in the same cycle while full
    vecs.push_back(mk(1, 1, 16'h0061, 1, 0, 16'h0044, 0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0062, 1, 0, 16'h0044, 0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0063, 1, 0, 16'h0044, 0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0064, 1, 0, 16'h0044, 0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0065, 0, 1, 16'h0061, 6, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0062, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0063, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0064, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0065, 0, 1, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0065, 0, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].stb, vecs[i].din, vecs[i].full);
      check($sformatf("v%0d valid", i), 32'(valid_o), 32'(vecs[i].ev));
      check($sformatf("v%0d data",  i), 32'(data_o),  32'(vecs[i].ed));
      check($sformatf("v%0d delay", i), 32'(delay_o), 32'(vecs[i].edl));
      check($sformatf("v%0d empty", i), 32'(empty_o), 32'(vecs[i].ee));
      check($sformatf("v%0d err",   i), 32'(err_o),   32'(vecs[i].eerr));
    end

    // mid-operation reset discards three queued words
    step(1, 1, 16'h0071, 1);
    step(1, 1, 16'h0072, 1);
    step(1, 1, 16'h0073, 1);
    check("queued empty", 32'(empty_o), 32'd0);
    step(0, 0, 16'h0000, 1);
    check("rst empty", 32'(empty_o), 32'd1);
    check("rst valid", 32'(valid_o), 32'd0);
    check("rst data",  32'(data_o),  32'd0);
    check("rst delay", 32'(delay_o), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 16'h0000, 0);
      check($sformatf("post-rst%0d valid", i), 32'(valid_o), 32'd0);
      check($sformatf("post-rst%0d empty", i), 32'(empty_o), 32'd1);
    end

    // long gap: event 0x55, 300 idle cycles, event 0x66
    step(0, 0, 16'h0000, 0);
    err_seen = 1'b0;
    step(1, 1, 16'h0055, 0);
    for (int i = 0; i < 306; i++) begin
      if (i == 300) step(1, 1, 16'h0066, 0);
      else          step(1, 0, 16'h0000, 0);
      if (valid_o) got.push_back({delay_o, data_o});
      if (err_o) err_seen = 1'b1;
    end
`ifdef FLOSTAMP_FILLER_EN
    exp_words = '{{7'd0, 16'h0055}, {7'd127, 16'h0055}, {7'd127, 16'h0055}, {7'd46, 16'h0066}};
`else
    exp_words = '{{7'd0, 16'h0055}, {7'd127, 16'h0066}};
`endif
    check("gap word count", 32'(got.size()), 32'(exp_words.size()));
    check("gap err", 32'(err_seen), 32'd0);
    for (int i = 0; i < exp_words.size(); i++) begin
      if (i < got.size()) check($sformatf("gap word%0d", i), 32'(got[i]), 32'(exp_words[i]));
      else                check($sformatf("gap word%0d missing", i), 32'hDEAD, 32'(exp_words[i]));
    end
    check("gap final empty", 32'(empty_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
